// File: rtl/rle_encoder.sv
// Run-length encoder for the word stream leaving the XOR stage.
// Consecutive equal words are folded into (value, count) pairs; each block,
// delimited by in_last, closes with a pair flagged out_last. Runs longer than
// MAX_RUN are split so that a count never wraps. Pairs leave through a single
// output register that can be reloaded in the same cycle it drains.
module rle_encoder #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_last,
  input  logic              out_ready
);

  // IDLE: no open run, RUN: run open, FLUSH: one closing pair still owed
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam logic [CNT_W-1:0] MAX_RUN  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [1:0]        state;
  logic [DATA_W-1:0] run_val;
  logic [CNT_W-1:0]  run_cnt;

  logic [1:0]        nxt_state;
  logic [DATA_W-1:0] nxt_val;
  logic [CNT_W-1:0]  nxt_cnt;
  logic              emit;
  logic [DATA_W-1:0] emit_data;
  logic [CNT_W-1:0]  emit_cnt;
  logic              emit_last;

  logic out_free;
  logic accept;
  logic extend;

  // The output register can take a new pair when empty or draining this cycle.
  assign out_free = !out_valid || out_ready;
  // Input is held off during reset, while the closing pair is owed, and under stall.
  assign in_ready = !rst && (state != FLUSH) && out_free;
  assign accept   = in_valid && in_ready;
  // Beat continues the open run only if equal and the count has headroom.
  assign extend   = (in_data == run_val) && (run_cnt != MAX_RUN);

  // Next-state and pair-generation decode for the run tracker.
  always_comb begin
    nxt_state = state;
    nxt_val   = run_val;
    nxt_cnt   = run_cnt;
    emit      = 1'b0;
    emit_data = run_val;
    emit_cnt  = run_cnt;
    emit_last = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_last) begin
            // Single-word block: close immediately, no run opened.
            emit      = 1'b1;
            emit_data = in_data;
            emit_cnt  = CNT_ONE;
            emit_last = 1'b1;
          end else begin
            nxt_val   = in_data;
            nxt_cnt   = CNT_ONE;
            nxt_state = RUN;
          end
        end else begin
          nxt_state = IDLE;
        end
      end
      RUN: begin
        if (accept) begin
          if (extend) begin
            if (in_last) begin
              emit      = 1'b1;
              emit_cnt  = run_cnt + CNT_ONE;
              emit_last = 1'b1;
              nxt_cnt   = CNT_ZERO;
              nxt_state = IDLE;
            end else begin
              nxt_cnt = run_cnt + CNT_ONE;
            end
          end else begin
            // Run terminated: ship it and start a new one with this word.
            emit    = 1'b1;
            nxt_val = in_data;
            nxt_cnt = CNT_ONE;
            if (in_last) begin
              // The new single-word run still needs its own closing pair.
              nxt_state = FLUSH;
            end else begin
              nxt_state = RUN;
            end
          end
        end else begin
          nxt_state = RUN;
        end
      end
      FLUSH: begin
        if (out_free) begin
          emit      = 1'b1;
          emit_cnt  = CNT_ONE;
          emit_last = 1'b1;
          nxt_cnt   = CNT_ZERO;
          nxt_state = IDLE;
        end else begin
          nxt_state = FLUSH;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_cnt   = CNT_ZERO;
      end
    endcase
  end

  // Run tracker state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      run_val <= {DATA_W{1'b0}};
      run_cnt <= CNT_ZERO;
    end else begin
      state   <= nxt_state;
      run_val <= nxt_val;
      run_cnt <= nxt_cnt;
    end
  end

  // Output pair register: load on emit, clear valid once drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= {DATA_W{1'b0}};
      out_count <= CNT_ZERO;
      out_last  <= 1'b0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_data  <= emit_data;
      out_count <= emit_cnt;
      out_last  <= emit_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_rle_encoder.sv
// Self-checking bench for rle_encoder: a queue-based scoreboard model plus
// directed scenarios with hand-computed pair lists.
module tb_rle_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [7:0]  out_count;
  logic        out_last;
  logic        out_ready;

  rle_encoder #(.DATA_W(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_count(out_count),
    .out_last(out_last), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  logic [40:0] pair;
  assign pair = {out_data, out_count, out_last};

  int checks = 0;
  int failures = 0;
  logic [40:0] exp_q[$];
  logic [40:0] got_q[$];
  bit          m_open = 1'b0;
  logic [31:0] m_val = 32'h0;
  int          m_cnt = 0;
  int          beats_acc = 0;
  int          sum_cnt = 0;
  int          bp_mode = 0;
  bit          lowcnt_en = 1'b0;
  int          lowcnt = 0;
  bit          prev_stall = 1'b0;
  logic [40:0] prev_pair = 41'h0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [40:0] mk(input logic [31:0] d, input int c, input bit l);
    logic [7:0] c8;
    c8 = c[7:0];
    return {d, c8, l};
  endfunction

  // Reference behaviour: plain run-length coding of accepted words, block by block.
  task automatic model_beat(input logic [31:0] d, input bit l);
    beats_acc++;
    if (!m_open) begin
      if (l) exp_q.push_back(mk(d, 1, 1'b1));
      else begin m_open = 1'b1; m_val = d; m_cnt = 1; end
    end else if (d == m_val && m_cnt < 255) begin
      m_cnt++;
      if (l) begin exp_q.push_back(mk(m_val, m_cnt, 1'b1)); m_open = 1'b0; end
    end else begin
      exp_q.push_back(mk(m_val, m_cnt, 1'b0));
      if (l) begin exp_q.push_back(mk(d, 1, 1'b1)); m_open = 1'b0; end
      else begin m_val = d; m_cnt = 1; end
    end
  endtask

  // Compare process: scoreboard every transferred pair, hold checks under stall.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_open = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", {out_valid, pair}, {1'b1, prev_pair});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_pair actual=%0h expected=none", pair);
        end else begin
          chk("pair", pair, exp_q.pop_front());
        end
        got_q.push_back(pair);
        sum_cnt += int'(out_count);
        chk("count_nonzero", (out_count != 8'd0), 1'b1);
      end
      if (in_valid && in_ready) model_beat(in_data, in_last);
      if (lowcnt_en && !in_ready) lowcnt++;
      prev_stall = out_valid && !out_ready;
      prev_pair  = pair;
    end
  end

  // Downstream backpressure: 0 = always ready, 1 = toggle, 2 = random.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        1:       out_ready = !out_ready;
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic send(input logic [31:0] d, input bit l);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=in_ready_low expected=accept");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (!(exp_q.size() == 0 && !out_valid) && n < 1000) begin
      @(posedge clk); #2; n++;
    end
    chk("drain_empty", {31'd0, out_valid, exp_q.size()}, 64'd0);
  endtask

  task automatic chk_got(input string nm, input int idx, input logic [40:0] e);
    if (idx < got_q.size()) chk(nm, got_q[idx], e);
    else begin
      checks++; failures++;
      $display("FAIL %s actual=missing expected=%0h", nm, e);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cur;
    rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {in_ready, out_valid, pair}, 64'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Single-word block straight after reset.
    got_q.delete();
    send(32'h1111, 1'b1);
    chk("single_pair_next_cycle", {out_valid, pair}, {1'b1, mk(32'h1111, 1, 1'b1)});
    chk("single_back_to_idle", in_ready, 1'b1);
    drain();
    chk("single_count", got_q.size(), 1);

    // 0,0,0,0x1111(last): run of three then a FLUSH pair.
    got_q.delete(); lowcnt = 0; lowcnt_en = 1'b1;
    send(32'h0, 1'b0); send(32'h0, 1'b0); send(32'h0, 1'b0); send(32'h1111, 1'b1);
    drain(); lowcnt_en = 1'b0;
    chk("flush_pairs", got_q.size(), 2);
    chk_got("flush_p0", 0, mk(32'h0, 3, 1'b0));
    chk_got("flush_p1", 1, mk(32'h1111, 1, 1'b1));
    chk("flush_ready_low_cycles", lowcnt, 1);

    // 300 equal words: split at 255.
    got_q.delete();
    for (int i = 0; i < 300; i++) send(32'h55555555, (i == 299));
    drain();
    chk("long_pairs", got_q.size(), 2);
    chk_got("long_p0", 0, mk(32'h55555555, 255, 1'b0));
    chk_got("long_p1", 1, mk(32'h55555555, 45, 1'b1));

    // Alternating words under toggling backpressure.
    got_q.delete(); bp_mode = 1;
    for (int i = 0; i < 6; i++) send((i % 2 == 0) ? 32'h1111 : 32'h0, (i == 5));
    drain(); bp_mode = 0;
    chk("alt_pairs", got_q.size(), 6);
    for (int i = 0; i < 6; i++)
      chk_got("alt_p", i, mk((i % 2 == 0) ? 32'h1111 : 32'h0, 1, (i == 5)));

    // Reset mid-run discards the open run.
    @(posedge clk); #1;
    got_q.delete();
    for (int i = 0; i < 4; i++) send(32'h1111, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrun_reset_outputs", {in_ready, out_valid, pair}, 64'd0);
    @(negedge clk);
    chk("midrun_reset_hold", {in_ready, out_valid, pair}, 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    send(32'h0, 1'b1);
    drain();
    chk("after_reset_pairs", got_q.size(), 1);
    chk_got("after_reset_p0", 0, mk(32'h0, 1, 1'b1));

    // Random stream with random backpressure against the scoreboard.
    got_q.delete(); beats_acc = 0; sum_cnt = 0; bp_mode = 2; cur = 32'h0;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        6:       cur = 32'h0;
        7:       cur = 32'h1111;
        8:       cur = 32'h1110;
        9:       cur = $urandom;
        default: cur = cur;
      endcase
      if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
      send(cur, (i == 399) || ($urandom_range(0, 15) == 0));
    end
    drain(); bp_mode = 0;
    chk("random_expand_sum", sum_cnt, beats_acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
